// File: rtl/chain_tail_collector.sv
// Daisy-chain tail collector: qualifies chain words, tags them with a channel index,
// checks frame completeness and buffers them in a FWFT FIFO. Optional: CHAIN_TAIL_FRAME_HEADER_EN.
module chain_tail_collector #(
  parameter int unsigned BITS_ADC   = 12,
  parameter int unsigned N_BLOCKS   = 8,
  parameter int unsigned CH_IDX_W   = 5,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned OUT_W      = 18
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          adc_ready,
  input  logic [BITS_ADC:0]             data_from_chain,
  output logic [OUT_W-1:0]              rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic                          frame_err,
  output logic                          ovf,
  input  logic                          clr_flags,
  output logic [7:0]                    err_cnt
);

  localparam int unsigned N_CH = 4 * N_BLOCKS;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam logic [CH_IDX_W-1:0] LastCh = CH_IDX_W'(N_CH - 1);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e                state_q, state_d;
  logic [CH_IDX_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [BITS_ADC-1:0]   din_q;
  logic                  din_v_q, rdy1_q, rdy2_q, rise;
  logic                  sample_wr, last_wr, err_ev;
  logic [OUT_W-1:0]      sample_word;

  logic                  push0, push1, acc0, acc1, pop, ovf_ev;
  logic [OUT_W-1:0]      wdata0, wdata1;
  logic [OUT_W-1:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d, space, n_acc;
  logic                  frame_err_q, frame_err_d, ovf_q, ovf_d, frame_done_q;
  logic [7:0]            err_cnt_q, err_cnt_d;

  // Input stage: one register for the chain word, two-stage adc_ready edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q   <= '0;
      din_v_q <= 1'b0;
      rdy1_q  <= 1'b0;
      rdy2_q  <= 1'b0;
    end else begin
      din_q   <= data_from_chain[BITS_ADC-1:0];
      din_v_q <= ~data_from_chain[BITS_ADC];
      rdy1_q  <= adc_ready;
      rdy2_q  <= rdy1_q;
    end
  end

  assign rise = rdy1_q & ~rdy2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ch_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_cnt_q <= ch_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_cnt_d = ch_cnt_q;
    case (state_q)
      StIdle: begin
        if (rise) begin
          state_d  = StCollect;
          ch_cnt_d = '0;
        end
      end
      StCollect: begin
        if (sample_wr) ch_cnt_d = ch_cnt_q + 1'b1;
        if (last_wr) begin
          state_d  = StIdle;
          ch_cnt_d = '0;
        end
        // A rise restarts collection whether or not the old frame just completed.
        if (rise) begin
          state_d  = StCollect;
          ch_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sample_wr   = (state_q == StCollect) & din_v_q;
    last_wr     = sample_wr & (ch_cnt_q == LastCh);
    err_ev      = ((state_q == StIdle) & din_v_q) | ((state_q == StCollect) & rise & ~last_wr);
    sample_word = {1'b0, ch_cnt_q, din_q};
  end

`ifdef CHAIN_TAIL_FRAME_HEADER_EN
  logic [OUT_W-2:0] frame_cnt_q, frame_cnt_d;
  logic [OUT_W-1:0] skid_q, skid_d;
  logic             skid_v_q, skid_v_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      skid_q      <= '0;
      skid_v_q    <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      skid_q      <= skid_d;
      skid_v_q    <= skid_v_d;
    end
  end

  // rise cannot repeat on the cycle after a rise, so a parked header never meets a new one.
  always_comb begin
    push0       = sample_wr;
    push1       = 1'b0;
    wdata0      = sample_word;
    wdata1      = sample_word;
    skid_d      = skid_q;
    skid_v_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (skid_v_q) begin
      push0  = 1'b1;
      wdata0 = skid_q;
      push1  = sample_wr;
    end else if (rise) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
      push0       = 1'b1;
      if (sample_wr) begin
        skid_v_d = 1'b1;
        skid_d   = {1'b1, frame_cnt_q};
      end else begin
        wdata0 = {1'b1, frame_cnt_q};
      end
    end
  end
`else
  always_comb begin
    push0  = sample_wr;
    push1  = 1'b0;
    wdata0 = sample_word;
    wdata1 = '0;
  end
`endif

  // FIFO with up to two ordered writes per cycle; a full FIFO accepts if it pops too.
  always_comb begin
    pop      = rd_valid & rd_ready;
    space    = LW'(FIFO_DEPTH) - level_q + LW'(pop);
    acc0     = push0 & (space != '0);
    acc1     = push1 & acc0 & (space >= LW'(2));
    ovf_ev   = (push0 & ~acc0) | (push1 & ~acc1);
    n_acc    = LW'(acc0) + LW'(acc1);
    level_d  = level_q + n_acc - LW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(n_acc);
    rd_ptr_d = rd_ptr_q + AW'(pop);
  end

  always_ff @(posedge clk) begin
    if (acc0) mem[wr_ptr_q] <= wdata0;
    if (acc1) mem[wr_ptr_q + AW'(1)] <= wdata1;
  end

  always_comb begin
    frame_err_d = err_ev | (frame_err_q & ~clr_flags);
    ovf_d       = ovf_ev | (ovf_q & ~clr_flags);
    if (err_ev) begin
      if (clr_flags)                err_cnt_d = 8'd1;
      else if (err_cnt_q == 8'hFF)  err_cnt_d = 8'hFF;
      else                          err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = clr_flags ? 8'd0 : err_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      frame_err_q  <= 1'b0;
      ovf_q        <= 1'b0;
      err_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      frame_err_q  <= frame_err_d;
      ovf_q        <= ovf_d;
      err_cnt_q    <= err_cnt_d;
      frame_done_q <= last_wr;
    end
  end

  assign rd_valid   = (level_q != '0);
  assign rd_data    = rd_valid ? mem[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign ovf        = ovf_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_chain_tail_collector.sv
// Scoreboard bench for chain_tail_collector (default build, header feature off).
module tb_chain_tail_collector;

  localparam int N_CH  = 32;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst, adc_ready, rd_valid, rd_ready, frame_done, frame_err, ovf, clr_flags;
  logic [12:0] data_from_chain;
  logic [17:0] rd_data;
  logic [6:0]  fifo_level;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  chain_tail_collector dut (
    .clk             (clk),
    .rst             (rst),
    .adc_ready       (adc_ready),
    .data_from_chain (data_from_chain),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .fifo_level      (fifo_level),
    .frame_done      (frame_done),
    .frame_err       (frame_err),
    .ovf             (ovf),
    .clr_flags       (clr_flags),
    .err_cnt         (err_cnt)
  );

  int          total = 0;
  int          bad   = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_e;
  bit          m_in_frame = 0;
  int          m_idx = 0;
  int          m_err = 0;
  bit          m_ovf = 0;
  int          m_done = 0;
  int          done_seen = 0;
  bit          rand_ready = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_err_inc();
    m_err = (m_err < 255) ? m_err + 1 : 255;
  endtask

  task automatic idle_cycle();
    if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
    data_from_chain = 13'h1000 | 13'($urandom_range(0, 4095));
    step();
  endtask

  task automatic settle();
    repeat (4) idle_cycle();
  endtask

  // Model of one valid chain word: tagged in arrival order, dropped and flagged outside a frame.
  task automatic send_word(input logic [11:0] d, input bit pop_credit);
    if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
    data_from_chain = {1'b0, d};
    if (m_in_frame) begin
      if (exp_q.size() < DEPTH || pop_credit) exp_q.push_back({1'b0, 5'(m_idx), d});
      else m_ovf = 1;
      m_idx++;
      if (m_idx == N_CH) begin
        m_in_frame = 0;
        m_done++;
      end
    end else begin
      m_err_inc();
    end
    step();
    data_from_chain = 13'h1FFF;
  endtask

  task automatic start_frame();
    adc_ready = 1'b1;
    data_from_chain = 13'h1FFF;
    if (m_in_frame) m_err_inc();
    m_in_frame = 1;
    m_idx      = 0;
    step();
    adc_ready = 1'b0;
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    m_err = 0;
    m_ovf = 0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_frame_err"}, frame_err, m_err != 0);
    chk({tag, "_err_cnt"}, err_cnt, m_err);
    chk({tag, "_ovf"}, ovf, m_ovf);
    chk({tag, "_frame_done_cnt"}, done_seen, m_done);
  endtask

  task automatic drain(input bit rnd);
    int n = 0;
    bit save = rand_ready;
    rand_ready = rnd;
    settle();
    while (exp_q.size() != 0 && n < 3000) begin
      if (!rnd) rd_ready = 1'b1;
      idle_cycle();
      n++;
    end
    rd_ready   = 1'b0;
    rand_ready = save;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
    end
    idle_cycle();
    chk("level_after_drain", fifo_level, 0);
    chk("rd_valid_after_drain", rd_valid, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) done_seen++;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got %0h expected none", rd_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rd_data", rd_data, mon_e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; adc_ready = 1'b0; rd_ready = 1'b0; clr_flags = 1'b0;
    data_from_chain = 13'h1FFF;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err_cnt", err_cnt, 0);

    // Normal frame, consumer always ready.
    rd_ready = 1'b1;
    start_frame();
    for (int i = 0; i < N_CH; i++) send_word(12'h100 + 12'(i), 0);
    drain(0);
    check_flags("normal");

    // Idle words interleaved, random consumer.
    rand_ready = 1;
    start_frame();
    for (int i = 0; i < N_CH; i++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      send_word(12'h100 + 12'(i), 0);
    end
    drain(1);
    check_flags("idle_filter");

    // Short frame then a full one.
    start_frame();
    for (int i = 0; i < 20; i++) send_word(12'($urandom), 0);
    start_frame();
    for (int i = 0; i < N_CH; i++) send_word(12'($urandom), 0);
    drain(1);
    check_flags("short");
    clear_flags();
    settle();
    check_flags("short_clr");

    // Overflow: three frames into a stalled FIFO.
    rand_ready = 0;
    rd_ready   = 1'b0;
    for (int f = 0; f < 3; f++) begin
      start_frame();
      for (int i = 0; i < N_CH; i++) send_word(12'($urandom), 0);
    end
    settle();
    chk("ovf_level", fifo_level, DEPTH);
    check_flags("ovf");
    clear_flags();
    settle();
    check_flags("ovf_clr");

    // Full FIFO with a pop on the same edge as the write.
    start_frame();
    send_word(12'hABC, 1);
    rd_ready = 1'b1;
    idle_cycle();
    rd_ready = 1'b0;
    settle();
    chk("full_pop_level", fifo_level, DEPTH);
    check_flags("full_pop");
    drain(0);

    // Random frames, some short.
    rand_ready = 1;
    for (int f = 0; f < 6; f++) begin
      int n;
      start_frame();
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : N_CH;
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) idle_cycle();
        send_word(12'($urandom), 0);
      end
      drain(1);
    end
    check_flags("random");

    // Complete a frame, then a stray word while idle.
    start_frame();
    for (int i = 0; i < N_CH; i++) send_word(12'($urandom), 0);
    drain(1);
    send_word(12'h5A5, 0);
    settle();
    check_flags("stray");

    // Reset mid-frame.
    rand_ready = 0;
    rd_ready   = 1'b0;
    start_frame();
    for (int i = 0; i < 10; i++) send_word(12'($urandom), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    m_in_frame = 0;
    m_err      = 0;
    m_ovf      = 0;
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    check_flags("mid_rst");

    // Recovery frame after reset.
    rand_ready = 1;
    start_frame();
    for (int i = 0; i < N_CH; i++) send_word(12'h300 + 12'(i), 0);
    drain(1);
    check_flags("recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chain_tail_collector.md
Name: chain_tail_collector

Overview:
- Sits at the tail of the ADC daisy chain, directly downstream of the last pixel block's `data_to_post`.
- Qualifies valid chain words (flag bit = 0) and tags each with a channel index in arrival order.
- Checks frame completeness against `adc_ready`.
- Buffers tagged samples in a FIFO drained by the readout interface through a valid/ready handshake.

Parameters:
- BITS_ADC, 12, ADC sample width; chain word is BITS_ADC+1 bits.
- N_BLOCKS, 8, number of daisy-chained blocks; N_CH = 4*N_BLOCKS channels per frame.
- CH_IDX_W, 5, channel index width; must satisfy 2^CH_IDX_W >= N_CH.
- FIFO_DEPTH, 64, FIFO entries; power of two.
- OUT_W, 18, output word width = 1+CH_IDX_W+BITS_ADC.

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  reset
- adc_ready  input  1  conversion-done strobe from ADC sequencer; rising edge starts a frame
- data_from_chain  input  BITS_ADC+1  tail word; bit[BITS_ADC]=0 valid sample, 1 idle
- rd_data  output  OUT_W  FIFO head word
- rd_valid  output  1  FIFO non-empty
- rd_ready  input  1  consumer accepts head word this cycle
- fifo_level  output  log2(FIFO_DEPTH)+1  current occupancy
- frame_done  output  1  one-cycle pulse when the N_CH-th word of a frame is written
- frame_err  output  1  sticky incomplete/stray-frame flag
- ovf  output  1  sticky FIFO overflow flag
- clr_flags  input  1  clears frame_err, ovf, err_cnt
- err_cnt  output  8  saturating count of frame errors

Behaviour:
- Reset is synchronous, active-high: clk rising edge with rst=1 resets all state; it is the only reset.
- On reset, all outputs are 0: rd_valid=0, rd_data=0, fifo_level=0, frame_done=0, frame_err=0, ovf=0, err_cnt=0.
- On reset, the FSM goes to IDLE, the FIFO pointers go to 0 and the channel counter goes to 0.
- Reset mid-frame discards FIFO contents and the partial frame.
- Input stage:
  - data_from_chain is registered once (din_q, din_v = ~bit[BITS_ADC]).
  - adc_ready is registered twice; rise = q1 & ~q2.
- FSM states and transitions:
  - IDLE: rise -> COLLECT, ch_cnt=0. A valid word while in IDLE is dropped and sets frame_err; err_cnt+1.
  - COLLECT: each din_v writes {1'b0, ch_cnt, din_q[BITS_ADC-1:0]} to the FIFO, then ch_cnt+1.
  - COLLECT: the write with ch_cnt==N_CH-1 pulses frame_done on the same edge as the write, and the FSM goes to IDLE.
  - COLLECT: rise before N_CH words -> frame_err=1, err_cnt+1 (saturates at 255), ch_cnt=0, stay in COLLECT.
  - COLLECT: rise coincident with din_v -> the word is written as the last word of the old frame. It does not count toward the new frame.
- Latency: a valid chain word presented before edge t is registered at t and written at t+1. rd_valid is high from t+1 (visible after the t+1 edge) when the FIFO was empty.
- FIFO:
  - First-word-fall-through; rd_data = head entry.
  - Pop on rd_valid & rd_ready. rd_ready while empty is ignored.
  - Write is accepted if level<FIFO_DEPTH, or if level==FIFO_DEPTH and a pop occurs the same cycle.
  - A rejected write sets ovf. ch_cnt still advances so channel tags remain aligned.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- clr_flags clears frame_err, ovf and err_cnt the next edge. If an error event occurs in the same cycle, the event wins (flag stays 1, err_cnt=1).
- No other state (FIFO, FSM) is affected by clr_flags.

Optional Feature:
- Macro: CHAIN_TAIL_FRAME_HEADER_EN.
- When defined:
  - On each rise that enters or restarts COLLECT, a header word {1'b1, frame_cnt[OUT_W-2:0]} is pushed before any sample of that frame.
  - frame_cnt is a free-running counter starting at 0 after reset and incrementing per header.
  - Header writes obey the same overflow rules.
  - If a sample write and a header write fall in the same cycle, the sample goes first and the header is delayed one cycle via a 1-entry skid register.
  - Sample latency for the new frame is unchanged relative to its header.
- When undefined: no header words, no frame_cnt, bit[OUT_W-1] of every word is 0.

Test Plan:
- Normal frame: reset; pulse adc_ready; feed 32 words {0, 12'h100+i}, i=0..31, rd_ready=1 -> 32 pops with rd_data = {0, i[4:0], 12'h100+i}; frame_done pulses once; frame_err=0.
- Idle filtering: interleave 13'h1FFF idle words between the 32 valid words -> identical output sequence; idle words never written.
- Short frame: 20 valid words then a new rise -> frame_err=1, err_cnt=1; the next 32 words are tagged 0..31; clr_flags -> frame_err=0, err_cnt=0.
- Overflow: FIFO_DEPTH=64, rd_ready=0, feed 3 frames (96 words) -> fifo_level=64, ovf=1; first 64 entries intact; last popped word has ch_idx 31 of frame 2.
- Full with simultaneous pop: level=64, rd_ready=1 while a valid word arrives -> word accepted, level stays 64, ovf stays 0.
- Stray word and reset: valid word while IDLE -> frame_err=1; assert rst mid-frame (after 10 words) -> next cycle rd_valid=0, fifo_level=0, all flags 0. With CHAIN_TAIL_FRAME_HEADER_EN, first word after a rise = 18'h20000, second header = 18'h20001.
